button_matrix_scanner: RTL and testbench
========================================

Name: button_matrix_scanner

Overview:
Scan controller for the keypad matrix that feeds button_matrix_decoder. It drives one column at a time and samples the row lines. It debounces across whole scans and presents one pressed key as a registered one-hot row/column pair for the decoder. Events use a valid/ack handshake toward the game FSM.

Parameters:
RWIDTH, 4, number of row lines (sensed inputs)
CWIDTH, 4, number of column lines (driven outputs)
SCAN_DIV, 1000, clk cycles each column is driven; minimum 4
DEBOUNCE_SCANS, 3, consecutive matching full scans required to accept a press or release; minimum 1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
row_in  input  RWIDTH  raw row lines, active-high, asynchronous to clk
col_drive  output  CWIDTH  one-hot active-high column drive; all-zero during EVAL
key_row  output  RWIDTH  one-hot row of the reported key (to decoder row)
key_col  output  CWIDTH  one-hot column of the reported key (to decoder col)
key_valid  output  1  event pending; key_row/key_col valid
key_ack  input  1  consumer acknowledge
key_held  output  1  a debounced key is currently down
overrun  output  1  1-cycle pulse: accepted press dropped because an event was pending

Behaviour:
- Reset (async, rst=1): col_drive=1 (column 0), key_row=0, key_col=0, key_valid=0, key_held=0, overrun=0.
  - Dwell counter, column index, stable counter, candidate and held-key registers all clear.
  - Scanning restarts from column 0 on the first clk after rst deasserts. Mid-scan reset discards all partial state.
- row_in passes through a 2-flop synchronizer. Only synchronized rows are used.
- FSM state SCAN:
  - Drive col_drive = 1<<c and count SCAN_DIV cycles.
  - On the last dwell cycle, sample the synchronized rows for column c.
  - Update the scan candidate: the lowest index idx=r*CWIDTH+c among set bits seen so far this scan.
  - Then c advances. After c=CWIDTH-1, go to EVAL.
- FSM state EVAL (1 cycle, col_drive=0):
  - If candidate equals the previous scan's candidate (including "none"), the stable counter increments, saturating at DEBOUNCE_SCANS. Otherwise it resets to 1.
  - The candidate becomes the previous candidate and is then cleared.
  - Next state is SCAN at c=0.
- Full scan period is CWIDTH*SCAN_DIV+1 cycles.
- Acceptance, evaluated in EVAL when the stable counter reaches DEBOUNCE_SCANS:
  - Candidate is a key K and differs from the held key, or nothing is held: key_held=1, held key := K, and a press event is posted.
  - Candidate is "none" while key_held=1: key_held=0, held key cleared, no event.
  - Same key still stable: no new event.
- Press event timing: the event registers on the cycle after EVAL.
  - If key_valid=0, or key_ack=1 in that same cycle: key_valid=1, key_row/key_col load K's one-hot pair.
  - Otherwise the event is dropped, overrun pulses for 1 cycle, and key_row/key_col keep the pending event.
- Handshake:
  - key_valid holds until key_ack is sampled high while key_valid=1. It clears on the next edge unless a new event loads in that same cycle.
  - key_ack while key_valid=0 is ignored.
  - key_row/key_col hold their last value after clearing.
- Latency: a key steady from the start of a scan is reported DEBOUNCE_SCANS scans later. key_valid rises 1 cycle after that scan's EVAL.
- Multiple simultaneous keys: the lowest index wins. Ghosting is not resolved.
- A direct key-to-key change without release (A→B stable) posts an event for B.

Test Plan:
Params: SCAN_DIV=4, DEBOUNCE_SCANS=2 (period 17).
- Reset and free-running scan:
  - Stimulus: assert rst with no keys, then release it.
  - Required: all outputs at reset values.
  - col_drive sequence is 0001 x4 cycles, 0010, 0100, 1000 (4 cycles each), then 0000 for 1 cycle, repeating.
  - key_valid never rises.
- Single press:
  - Stimulus: hold row_in=0100 whenever col_drive=0010 (key r2,c1).
  - Required: key_valid=1 one cycle after the 2nd EVAL; key_row=0100, key_col=0010; decoder yields 9; key_held=1.
  - key_valid stays 1 until key_ack. It is 0 the cycle after ack, and no repeat event follows while the key stays held.
- Bounce:
  - Stimulus: key r0,c0 present for exactly one scan.
  - Required: no event; key_held=0.
- Multi-key:
  - Stimulus: r1,c3 and r2,c0 pressed together.
  - Required: reported key_row=0010, key_col=1000 (idx 7).
- Overrun:
  - Stimulus: press r2,c1 and leave it unacked; release for 2 scans; press r3,c3 for 2 scans.
  - Required: overrun 1-cycle pulse; key_row/key_col remain 0100/0010.
  - After ack then re-press r3,c3: event carries 1000/1000 (idx 15).
- Reset mid-operation:
  - Stimulus: assert rst mid-dwell on column 2 while key_valid=1.
  - Required: outputs return to reset values immediately, and scanning restarts at column 0.

Source files
------------

// File: rtl/button_matrix_scanner.sv
// Keypad matrix scanner: drives one column at a time, debounces whole scans and
// reports the lowest-index pressed key as a one-hot row/col pair with valid/ack.
module button_matrix_scanner #(
  parameter int RWIDTH         = 4,
  parameter int CWIDTH         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RWIDTH-1:0] row_in,
  output logic [CWIDTH-1:0] col_drive,
  output logic [RWIDTH-1:0] key_row,
  output logic [CWIDTH-1:0] key_col,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              key_held,
  output logic              overrun
);
  localparam int RB = (RWIDTH > 1) ? $clog2(RWIDTH) : 1;
  localparam int CB = (CWIDTH > 1) ? $clog2(CWIDTH) : 1;
  localparam int IB = $clog2(RWIDTH*CWIDTH + 1);
  localparam int DB = $clog2(SCAN_DIV);
  localparam int SB = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic {SCAN, EVAL} state_t;

  state_t            state_q, state_d;
  logic [RWIDTH-1:0] row_s1_q, row_s2_q;
  logic [DB-1:0]     dwell_q, dwell_d;
  logic [CB-1:0]     col_q, col_d;
  logic              cand_vld_q, cand_vld_d;
  logic [RB-1:0]     cand_r_q, cand_r_d;
  logic [CB-1:0]     cand_c_q, cand_c_d;
  logic              prev_vld_q, prev_vld_d;
  logic [RB-1:0]     prev_r_q, prev_r_d;
  logic [CB-1:0]     prev_c_q, prev_c_d;
  logic [SB-1:0]     stable_q, stable_d;
  logic              held_q, held_d;
  logic [RB-1:0]     held_r_q, held_r_d;
  logic [CB-1:0]     held_c_q, held_c_d;
  logic              key_valid_q, key_valid_d;
  logic [RWIDTH-1:0] key_row_q, key_row_d;
  logic [CWIDTH-1:0] key_col_q, key_col_d;
  logic              overrun_q, overrun_d;

  logic              col_hit;
  logic [RB-1:0]     col_r;
  logic [IB-1:0]     hit_idx, cand_idx;
  logic              same, press;

  // Within one column the lowest row gives the lowest index r*CWIDTH+c.
  always_comb begin
    col_hit = 1'b0;
    col_r   = '0;
    for (int r = RWIDTH-1; r >= 0; r--) begin
      if (row_s2_q[r]) begin
        col_hit = 1'b1;
        col_r   = RB'(r);
      end
    end
  end

  assign hit_idx  = IB'(col_r) * IB'(CWIDTH) + IB'(col_q);
  assign cand_idx = IB'(cand_r_q) * IB'(CWIDTH) + IB'(cand_c_q);
  assign same     = (cand_vld_q == prev_vld_q) &&
                    (!cand_vld_q || (cand_r_q == prev_r_q && cand_c_q == prev_c_q));

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    col_d       = col_q;
    cand_vld_d  = cand_vld_q;
    cand_r_d    = cand_r_q;
    cand_c_d    = cand_c_q;
    prev_vld_d  = prev_vld_q;
    prev_r_d    = prev_r_q;
    prev_c_d    = prev_c_q;
    stable_d    = stable_q;
    held_d      = held_q;
    held_r_d    = held_r_q;
    held_c_d    = held_c_q;
    key_valid_d = key_valid_q;
    key_row_d   = key_row_q;
    key_col_d   = key_col_q;
    overrun_d   = 1'b0;
    press       = 1'b0;
    case (state_q)
      SCAN: begin
        if (dwell_q == DB'(SCAN_DIV-1)) begin
          dwell_d = '0;
          if (col_hit && (!cand_vld_q || hit_idx < cand_idx)) begin
            cand_vld_d = 1'b1;
            cand_r_d   = col_r;
            cand_c_d   = col_q;
          end
          if (col_q == CB'(CWIDTH-1)) begin
            col_d   = '0;
            state_d = EVAL;
          end else begin
            col_d = col_q + CB'(1);
          end
        end else begin
          dwell_d = dwell_q + DB'(1);
        end
      end
      EVAL: begin
        if (!same)
          stable_d = SB'(1);
        else if (stable_q != SB'(DEBOUNCE_SCANS))
          stable_d = stable_q + SB'(1);
        prev_vld_d = cand_vld_q;
        prev_r_d   = cand_r_q;
        prev_c_d   = cand_c_q;
        cand_vld_d = 1'b0;
        cand_r_d   = '0;
        cand_c_d   = '0;
        state_d    = SCAN;
        if (stable_d == SB'(DEBOUNCE_SCANS)) begin
          if (cand_vld_q && (!held_q || cand_r_q != held_r_q || cand_c_q != held_c_q)) begin
            press    = 1'b1;
            held_d   = 1'b1;
            held_r_d = cand_r_q;
            held_c_d = cand_c_q;
          end else if (!cand_vld_q && held_q) begin
            held_d   = 1'b0;
            held_r_d = '0;
            held_c_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
    // An ack in the same cycle as a new press frees the slot for it.
    if (key_valid_q && key_ack) key_valid_d = 1'b0;
    if (press) begin
      if (!key_valid_q || key_ack) begin
        key_valid_d = 1'b1;
        key_row_d   = RWIDTH'(1) << cand_r_q;
        key_col_d   = CWIDTH'(1) << cand_c_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1_q    <= '0;
      row_s2_q    <= '0;
      state_q     <= SCAN;
      dwell_q     <= '0;
      col_q       <= '0;
      cand_vld_q  <= 1'b0;
      cand_r_q    <= '0;
      cand_c_q    <= '0;
      prev_vld_q  <= 1'b0;
      prev_r_q    <= '0;
      prev_c_q    <= '0;
      stable_q    <= '0;
      held_q      <= 1'b0;
      held_r_q    <= '0;
      held_c_q    <= '0;
      key_valid_q <= 1'b0;
      key_row_q   <= '0;
      key_col_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      row_s1_q    <= row_in;
      row_s2_q    <= row_s1_q;
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      cand_vld_q  <= cand_vld_d;
      cand_r_q    <= cand_r_d;
      cand_c_q    <= cand_c_d;
      prev_vld_q  <= prev_vld_d;
      prev_r_q    <= prev_r_d;
      prev_c_q    <= prev_c_d;
      stable_q    <= stable_d;
      held_q      <= held_d;
      held_r_q    <= held_r_d;
      held_c_q    <= held_c_d;
      key_valid_q <= key_valid_d;
      key_row_q   <= key_row_d;
      key_col_q   <= key_col_d;
      overrun_q   <= overrun_d;
    end
  end

  assign col_drive = (state_q == SCAN) ? (CWIDTH'(1) << col_q) : '0;
  assign key_row   = key_row_q;
  assign key_col   = key_col_q;
  assign key_valid = key_valid_q;
  assign key_held  = held_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_button_matrix_scanner.sv
// Bench for button_matrix_scanner: a scan-level model of the keypad is checked
// against the DUT every cycle, plus directed literal checks per scenario.
module tb_button_matrix_scanner;
  localparam int RW = 4, CW = 4, SD = 4, DEB = 2;
  localparam int PER = CW*SD + 1;
  localparam int EVAL_PH = CW*SD;

  typedef logic [CW-1:0][RW-1:0] mat_t;   // mat[c][r]: key at row r, column c

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_ack = 1'b0;
  logic [RW-1:0] row_in;
  logic [CW-1:0] col_drive, key_col;
  logic [RW-1:0] key_row;
  logic          key_valid, key_held, overrun;
  mat_t          mat = '0;

  int pass_cnt = 0, total_cnt = 0, ovr_seen = 0;

  // Model state: phase of the current cycle within a scan, keys as flat indices (-1 = none).
  int            m_phase = 0, m_prev = -1, m_stable = 0, m_held = -1, m_cand = -1;
  logic          m_valid = 1'b0, m_ovr = 1'b0;
  logic [RW-1:0] m_row = '0;
  logic [CW-1:0] m_col = '0;
  mat_t          scan_mat = '0;
  bit            m_press;

  button_matrix_scanner #(.RWIDTH(RW), .CWIDTH(CW), .SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_drive(col_drive), .key_row(key_row),
    .key_col(key_col), .key_valid(key_valid), .key_ack(key_ack), .key_held(key_held),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Physical matrix: a driven column lights the rows of its pressed keys.
  always_comb begin
    row_in = '0;
    for (int c = 0; c < CW; c++)
      if (col_drive[c]) row_in = row_in | mat[c];
  end

  function automatic int lowest_key(input mat_t m);
    for (int i = 0; i < RW*CW; i++)
      if (m[i % CW][i / CW]) return i;
    return -1;
  endfunction

  function automatic mat_t key(input int r, input int c);
    mat_t m;
    m = '0;
    m[c][r] = 1'b1;
    return m;
  endfunction

  function automatic int oh_idx(input logic [RW-1:0] r, input logic [CW-1:0] c);
    int ri, ci;
    ri = -100;
    ci = -100;
    for (int i = 0; i < RW; i++) if (r[i]) ri = i;
    for (int i = 0; i < CW; i++) if (c[i]) ci = i;
    return ri*CW + ci;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else pass_cnt++;
  endtask

  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_phase = 0; m_prev = -1; m_stable = 0; m_held = -1; m_cand = -1;
        m_valid = 1'b0; m_ovr = 1'b0; m_row = '0; m_col = '0; scan_mat = '0;
      end else begin
        m_press = 1'b0;
        m_ovr   = 1'b0;
        if (m_phase == 0) scan_mat = mat;
        if (m_phase == EVAL_PH) begin
          m_cand   = lowest_key(scan_mat);
          m_stable = (m_cand == m_prev) ? ((m_stable < DEB) ? m_stable + 1 : DEB) : 1;
          m_prev   = m_cand;
          if (m_stable == DEB) begin
            if (m_cand >= 0 && m_cand != m_held) begin
              m_press = 1'b1;
              m_held  = m_cand;
            end else if (m_cand < 0) begin
              m_held = -1;
            end
          end
        end
        if (m_press && (!m_valid || key_ack)) begin
          m_valid = 1'b1;
          m_row   = RW'(1) << (m_cand / CW);
          m_col   = CW'(1) << (m_cand % CW);
        end else begin
          if (m_press) m_ovr = 1'b1;
          if (key_ack) m_valid = 1'b0;
        end
        m_phase = (m_phase + 1) % PER;
      end
    end
  end

  initial begin : compare
    logic [CW-1:0] exp_cd;
    forever begin
      @(negedge clk);
      exp_cd = (m_phase < EVAL_PH) ? (CW'(1) << (m_phase / SD)) : '0;
      chk("cycle", {col_drive, key_row, key_col, key_valid, key_held, overrun},
                   {exp_cd, m_row, m_col, m_valid, (m_held >= 0), m_ovr});
      if (overrun) ovr_seen++;
    end
  end

  task automatic wait_eval();
    do @(negedge clk); while (m_phase != EVAL_PH);
    #1;
  endtask

  task automatic scans(input int n);
    repeat (n) wait_eval();
  endtask

  task automatic set_keys(input mat_t m);
    wait_eval();
    mat = m;
  endtask

  task automatic do_ack();
    @(posedge clk); #1 key_ack = 1'b1;
    @(posedge clk); #1 key_ack = 1'b0;
  endtask

  initial begin : stim
    int ovr_before;
    // Reset and free-running scan
    repeat (3) @(negedge clk);
    chk("rst_col", col_drive, 4'b0001);
    chk("rst_outs", {key_row, key_col, key_valid, key_held, overrun}, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);      chk("col_ph0", col_drive, 4'b0001);
    repeat (4) @(negedge clk);  chk("col_ph4", col_drive, 4'b0010);
    repeat (12) @(negedge clk); chk("col_eval", col_drive, 4'b0000);
    repeat (3*PER) @(negedge clk);
    chk("idle_novalid", key_valid, 1'b0);

    // Single press r2,c1
    set_keys(key(2, 1));
    wait_eval(); chk("press_scan1", key_valid, 1'b0);
    wait_eval(); chk("press_eval2", key_valid, 1'b0);
    @(negedge clk);
    chk("press_valid", key_valid, 1'b1);
    chk("press_row", key_row, 4'b0100);
    chk("press_col", key_col, 4'b0010);
    chk("press_idx", oh_idx(key_row, key_col), 9);
    chk("press_held", key_held, 1'b1);
    chk("model_held", m_held, 9);
    scans(2); chk("press_hold", key_valid, 1'b1);
    do_ack();
    @(negedge clk); chk("ack_clear", key_valid, 1'b0);
    scans(3);
    chk("no_repeat", key_valid, 1'b0);
    chk("still_held", key_held, 1'b1);
    set_keys('0); scans(2);
    @(negedge clk); chk("released", key_held, 1'b0);

    // Bounce: key present for exactly one scan
    set_keys(key(0, 0));
    set_keys('0);
    scans(3);
    chk("bounce_valid", key_valid, 1'b0);
    chk("bounce_held", key_held, 1'b0);

    // Multi-key: idx 7 beats idx 8
    set_keys(key(1, 3) | key(2, 0));
    scans(2);
    @(negedge clk);
    chk("multi_row", key_row, 4'b0010);
    chk("multi_col", key_col, 4'b1000);
    chk("multi_idx", oh_idx(key_row, key_col), 7);
    do_ack();
    set_keys('0); scans(2);

    // Overrun
    ovr_before = ovr_seen;
    set_keys(key(2, 1)); scans(2);
    @(negedge clk); chk("ovr_first", key_valid, 1'b1);
    set_keys('0); scans(1);
    set_keys(key(3, 3)); scans(2);
    @(negedge clk);
    chk("ovr_pulse", overrun, 1'b1);
    chk("ovr_row", key_row, 4'b0100);
    chk("ovr_col", key_col, 4'b0010);
    chk("ovr_valid", key_valid, 1'b1);
    @(negedge clk); #1;
    chk("ovr_once", overrun, 1'b0);
    chk("ovr_count", ovr_seen - ovr_before, 1);
    do_ack();
    @(negedge clk); chk("ovr_acked", key_valid, 1'b0);
    set_keys('0); scans(1);
    set_keys(key(3, 3)); scans(2);
    @(negedge clk);
    chk("repress_valid", key_valid, 1'b1);
    chk("repress_row", key_row, 4'b1000);
    chk("repress_col", key_col, 4'b1000);
    chk("repress_idx", oh_idx(key_row, key_col), 15);

    // Reset mid-dwell on column 2 with an event pending
    do @(negedge clk); while (m_phase != 2*SD + 1);
    chk("pre_rst_col", col_drive, 4'b0100);
    #1 rst = 1'b1;
    #1;
    chk("mr_col", col_drive, 4'b0001);
    chk("mr_outs", {key_row, key_col, key_valid, key_held, overrun}, '0);
    mat = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);      chk("mr_restart", col_drive, 4'b0001);
    repeat (4) @(negedge clk); chk("mr_col1", col_drive, 4'b0010);
    scans(2);
    chk("mr_quiet", key_valid, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
